// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch queue.
// Entry layout, FSM encoding and PC step size.
package fetch_pkg;

  localparam int WIDTH   = 32;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    FETCH,
    DRAIN
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Bundle of the imem request/response bus, redirect and decode ports.
// master = fetch queue side, slave = environment side.
interface instr_fetch_queue_if;
  import fetch_pkg::*;

  logic             redirect_i;
  logic [WIDTH-1:0] redirect_pc_i;
  logic             imem_req_o;
  logic [WIDTH-1:0] imem_addr_o;
  logic             imem_gnt_i;
  logic             imem_rvalid_i;
  logic [WIDTH-1:0] imem_rdata_i;
  logic             instr_valid_o;
  logic [WIDTH-1:0] instr_o;
  logic [WIDTH-1:0] instr_pc_o;
  logic             instr_ready_i;

  modport master (
    input  redirect_i,
    input  redirect_pc_i,
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i,
    input  imem_rvalid_i,
    input  imem_rdata_i,
    output instr_valid_o,
    output instr_o,
    output instr_pc_o,
    input  instr_ready_i
  );

  modport slave (
    output redirect_i,
    output redirect_pc_i,
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i,
    output imem_rvalid_i,
    output imem_rdata_i,
    input  instr_valid_o,
    input  instr_o,
    input  instr_pc_o,
    output instr_ready_i
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries.
// Pointers carry an extra wrap bit to tell full from empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  fetch_entry_t           din,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         full;
  logic         do_push;
  logic         do_pop;

  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];

  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves this cycle
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst && !clear)
      mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch PC -> imem requests -> PC-tagged instruction queue for decode.
// Define FETCH_STATS_EN to add stall/flush counter outputs.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_queue_if.master bus
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]         stall_cnt_o,
  output logic [31:0]         flush_cnt_o
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e     state;
  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] resp_pc;
  logic [CW-1:0]    outstanding;
  logic [CW-1:0]    discard;
  logic [CW-1:0]    fifo_count;
  logic [CW-1:0]    drop_cnt;
  logic [CW:0]      in_use;
  logic             fifo_empty;
  logic             req;
  logic             fire;
  logic             push;
  logic             pop;
  logic             redirect;
  logic             rvalid;
  fetch_entry_t     din;
  fetch_entry_t     head;

  assign redirect = bus.redirect_i;
  assign rvalid   = bus.imem_rvalid_i;

  // Credit covers both queued entries and responses still in flight
  assign in_use = {1'b0, fifo_count} + {1'b0, outstanding};
  assign req    = !rst && (state == FETCH) && !redirect &&
                  (in_use < (CW+1)'(DEPTH));
  assign fire   = req && bus.imem_gnt_i;
  assign push   = (state == FETCH) && rvalid && !redirect;
  assign pop    = !fifo_empty && bus.instr_ready_i && !redirect;

  assign drop_cnt  = outstanding - CW'(rvalid);
  assign din.pc    = resp_pc;
  assign din.instr = bus.imem_rdata_i;

  assign bus.imem_req_o    = req;
  assign bus.imem_addr_o   = fetch_pc;
  assign bus.instr_valid_o = !fifo_empty;
  assign bus.instr_o       = head.instr;
  assign bus.instr_pc_o    = head.pc;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (redirect),
    .din   (din),
    .head  (head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CW'(fire) - CW'(rvalid);
      if (redirect) begin
        fetch_pc <= bus.redirect_pc_i;
        resp_pc  <= bus.redirect_pc_i;
        discard  <= drop_cnt;
        state    <= (drop_cnt != '0) ? DRAIN : FETCH;
      end else begin
        if (fire)
          fetch_pc <= fetch_pc + WIDTH'(PC_STEP);
        unique case (state)
          FETCH: begin
            if (rvalid)
              resp_pc <= resp_pc + WIDTH'(PC_STEP);
          end
          DRAIN: begin
            if (rvalid) begin
              discard <= discard - 1'b1;
              if (discard == CW'(1))
                state <= FETCH;
            end
          end
        endcase
      end
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if ((state == FETCH) && !req && !redirect &&
          (stall_cnt_o != '1))
        stall_cnt_o <= stall_cnt_o + 1'b1;
      if (redirect && (flush_cnt_o != '1))
        flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue.
// Queue-level reference model plus directed scenarios.
module tb_instr_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_queue_if bus ();

`ifdef FETCH_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  instr_fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FETCH_STATS_EN
    ,
    .stall_cnt_o (stall_cnt),
    .flush_cnt_o (flush_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  // Instruction memory: answers granted requests in order
  logic [31:0] pend[$];
  logic [31:0] glog[$];
  logic [31:0] poplog[$];
  bit          rv_en = 1'b1;

  initial begin
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend.delete();
      end else begin
        if (bus.imem_rvalid_i && pend.size() > 0)
          pend.delete(0);
        if (bus.imem_req_o && bus.imem_gnt_i) begin
          pend.push_back(bus.imem_addr_o);
          glog.push_back(bus.imem_addr_o);
        end
      end
      @(posedge clk);
      #2;
      bus.imem_rvalid_i = rv_en && pend.size() > 0;
      bus.imem_rdata_i  = (pend.size() > 0) ? mem_word(pend[0]) : '0;
    end
  end

  // Reference model: per-request tags, queue of delivered words
  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } infl_t;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  infl_t       infl[$];
  ent_t        mq[$];
  logic [31:0] m_pc = '0;
  logic [31:0] m_stall = '0;
  logic [31:0] m_flush = '0;
  bit          chk_en = 1'b0;
  bit          drain;
  bit          exp_req;
  bit          had;
  infl_t       f;
  ent_t        e;

  always @(negedge clk) begin
    if (chk_en) begin
      drain = 1'b0;
      foreach (infl[i]) if (infl[i].stale) drain = 1'b1;
      exp_req = !rst && !bus.redirect_i && !drain &&
                (mq.size() + infl.size() < DEPTH);
      chk("req", bus.imem_req_o, exp_req);
      if (exp_req) chk("addr", bus.imem_addr_o, m_pc);
      chk("valid", bus.instr_valid_o, mq.size() > 0);
      if (mq.size() > 0) begin
        chk("instr", bus.instr_o, mq[0].instr);
        chk("instr_pc", bus.instr_pc_o, mq[0].pc);
      end
`ifdef FETCH_STATS_EN
      chk("stall_cnt", stall_cnt, m_stall);
      chk("flush_cnt", flush_cnt, m_flush);
`endif
      if (rst) begin
        mq.delete();
        infl.delete();
        m_pc    = 32'h0;
        m_stall = '0;
        m_flush = '0;
      end else begin
        had = mq.size() > 0;
        if (!drain && !bus.redirect_i && !exp_req && m_stall != '1)
          m_stall++;
        if (bus.imem_rvalid_i && infl.size() > 0) begin
          f = infl.pop_front();
          if (!f.stale && !bus.redirect_i) begin
            e.pc    = f.addr;
            e.instr = bus.imem_rdata_i;
            mq.push_back(e);
          end
        end
        if (bus.redirect_i) begin
          if (m_flush != '1) m_flush++;
          mq.delete();
          foreach (infl[i]) infl[i].stale = 1'b1;
          m_pc = bus.redirect_pc_i;
        end else begin
          if (had && bus.instr_ready_i) begin
            mq.delete(0);
            poplog.push_back(bus.instr_pc_o);
          end
          if (exp_req && bus.imem_gnt_i) begin
            f.addr  = m_pc;
            f.stale = 1'b0;
            infl.push_back(f);
            m_pc += 32'd4;
          end
        end
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(bit gnt, bit rdy, bit rv);
    rst                = 1'b1;
    bus.redirect_i     = 1'b0;
    bus.redirect_pc_i  = '0;
    bus.imem_gnt_i     = 1'b0;
    bus.instr_ready_i  = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    glog.delete();
    poplog.delete();
    rst               = 1'b0;
    bus.imem_gnt_i    = gnt;
    bus.instr_ready_i = rdy;
    rv_en             = rv;
  endtask

  int first;

  initial begin
    // 1: streaming fetch
    do_reset(1, 1, 1);
    first = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.instr_valid_o && first < 0) first = i;
      tick();
    end
    chk("s1_first_valid_cycle", first, 2);
    chk("s1_addr0", glog[0], 32'h0);
    chk("s1_addr1", glog[1], 32'h4);
    chk("s1_addr2", glog[2], 32'h8);
    chk("s1_pop0", poplog[0], 32'h0);
    chk("s1_pop1", poplog[1], 32'h4);
    chk("s1_pop2", poplog[2], 32'h8);

    // 2: decode stalled, credit limit
    do_reset(1, 0, 1);
    tick(8);
    bus.instr_ready_i = 1'b1;
    @(negedge clk);
    chk("s2_grants", glog.size(), 4);
    chk("s2_last_addr", glog[3], 32'hC);
    chk("s2_req_low", bus.imem_req_o, 1'b0);
    chk("s2_valid_held", bus.instr_valid_o, 1'b1);
`ifdef FETCH_STATS_EN
    chk("s2_stall_cnt", stall_cnt, 4);
`endif
    tick();
    bus.instr_ready_i = 1'b0;
    tick(4);
    @(negedge clk);
    chk("s2_grants_after_pop", glog.size(), 5);
    chk("s2_new_addr", glog[4], 32'h10);
    tick();

    // 3: redirect with two requests in flight
    do_reset(1, 1, 0);
    tick(2);
    bus.imem_gnt_i = 1'b0;
    rv_en          = 1'b1;
    tick(3);
    bus.imem_gnt_i = 1'b1;
    rv_en          = 1'b0;
    tick(2);
    bus.imem_gnt_i    = 1'b0;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h100;
    @(negedge clk);
    chk("s3_no_req_redirect", bus.imem_req_o, 1'b0);
    tick();
    bus.redirect_i = 1'b0;
    rv_en          = 1'b1;
    bus.imem_gnt_i = 1'b1;
    @(negedge clk);
    chk("s3_drain_req_a", bus.imem_req_o, 1'b0);
    tick();
    @(negedge clk);
    chk("s3_drain_req_b", bus.imem_req_o, 1'b0);
    tick();
    @(negedge clk);
    chk("s3_req_after_drain", bus.imem_req_o, 1'b1);
    chk("s3_addr_after_drain", bus.imem_addr_o, 32'h100);
    tick(6);
    chk("s3_grant_seq", glog[4], 32'h100);
    chk("s3_pop_before0", poplog[0], 32'h0);
    chk("s3_pop_before1", poplog[1], 32'h4);
    chk("s3_first_pop_after", poplog[2], 32'h100);
`ifdef FETCH_STATS_EN
    chk("s3_flush_cnt", flush_cnt, 1);
`endif

    // 4: redirect coincident with rvalid and pop
    do_reset(1, 1, 0);
    tick(2);
    bus.imem_gnt_i    = 1'b0;
    rv_en             = 1'b1;
    bus.instr_ready_i = 1'b0;
    tick();
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h200;
    bus.instr_ready_i = 1'b1;
    @(negedge clk);
    chk("s4_valid_at_redirect", bus.instr_valid_o, 1'b1);
    chk("s4_rvalid_at_redirect", bus.imem_rvalid_i, 1'b1);
    tick();
    bus.redirect_i = 1'b0;
    bus.imem_gnt_i = 1'b1;
    @(negedge clk);
    chk("s4_empty_after", bus.instr_valid_o, 1'b0);
    chk("s4_req_no_drain", bus.imem_req_o, 1'b1);
    chk("s4_addr_target", bus.imem_addr_o, 32'h200);
    chk("s4_pop_ignored", poplog.size(), 0);
    tick(5);
    chk("s4_first_pop", poplog[0], 32'h200);
    chk("s4_second_pop", poplog[1], 32'h204);

    // 5: grant withheld
    do_reset(0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("s5_req_held", bus.imem_req_o, 1'b1);
      chk("s5_addr_held", bus.imem_addr_o, 32'h0);
      tick();
    end
    bus.imem_gnt_i = 1'b1;
    tick();
    bus.imem_gnt_i = 1'b0;
    @(negedge clk);
    chk("s5_one_grant", glog.size(), 1);
    chk("s5_addr_advanced", bus.imem_addr_o, 32'h4);
    tick(3);

    // 6: fetch address wraps
    do_reset(0, 1, 1);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    bus.redirect_i = 1'b0;
    bus.imem_gnt_i = 1'b1;
    tick(6);
    chk("s6_addr_top", glog[0], 32'hFFFF_FFFC);
    chk("s6_addr_wrap", glog[1], 32'h0);
    chk("s6_pop_top", poplog[0], 32'hFFFF_FFFC);
    chk("s6_pop_wrap", poplog[1], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
